lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//   Two-lane load/store request port in front of a single-ported data memory.
//   Accepted requests go into an in-order FIFO; the head is issued to memory
//   every cycle the FIFO is non-empty. The response comes back one cycle
//   after issue. Illegal, misaligned and out-of-window requests are popped
//   without touching memory and come back with rsp_fault set.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   reqK_valid/ready         lane K handshake (K = 0, 1)
//   reqK_addr/wdata          lane K byte address and store data
//   reqK_mem_read/mem_write  lane K op code (read: 1 LBU 2 LHU 3 LB 4 LH 5 LW;
//                            write: 1 SB 2 SH 4 SW)
//   reqK_tag                 lane K tag, echoed on the response
//   mem_addr/read/write/wdata  memory command, driven combinationally from the head
//   mem_rdata                combinational read data from memory
//   rsp_valid/tag/data/fault one-cycle response pulse; fields hold when idle
//
// Handshake: a lane transfers on a rising edge where its valid and ready are
// both high. Ready never depends on the same lane's valid; req1_ready does
// depend on req0_valid because lane 0 takes the first free slot. There is no
// response backpressure.
//
// Timing: accepted at edge N, the entry is the issued head in the cycle that
// follows (if nothing is ahead of it); the response is registered at the
// next edge.
module lsu_mem_port #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned MEM_BYTES = 32768,
   parameter int unsigned DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic [2:0]  req0_mem_read,
   input  logic [2:0]  req0_mem_write,
   input  logic [4:0]  req0_tag,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic [2:0]  req1_mem_read,
   input  logic [2:0]  req1_mem_write,
   input  logic [4:0]  req1_tag,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_read,
   output logic [2:0]  mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [4:0]  rsp_tag,
   output logic [31:0] rsp_data,
   output logic        rsp_fault
);

   // DEPTH is a power of two (>= 2) so pointers wrap naturally.
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = 75;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

   localparam logic [2:0] RD_LHU = 3'b010;
   localparam logic [2:0] RD_LH  = 3'b100;
   localparam logic [2:0] RD_LW  = 3'b101;
   localparam logic [2:0] WR_SB  = 3'b001;
   localparam logic [2:0] WR_SH  = 3'b010;
   localparam logic [2:0] WR_SW  = 3'b100;

   // Entry layout: {tag[74:70], write[69:67], read[66:64], wdata[63:32], addr[31:0]}
   logic [ENT_W-1:0] ent_q [DEPTH];
   logic [ENT_W-1:0] ent_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic        rsp_valid_q, rsp_valid_d;
   logic [4:0]  rsp_tag_q, rsp_tag_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_fault_q, rsp_fault_d;

   logic [CNT_W-1:0] free;
   logic             pop, push0, push1;

   logic [ENT_W-1:0] head;
   logic [31:0]      h_addr, h_wdata;
   logic [2:0]       h_rd, h_wr;
   logic [4:0]       h_tag;
   logic             is_ld, is_st, bad_op, is_half, is_word, misaligned, out_win, fault;
   logic [32:0]      addr_x, win_lo, win_hi;

   // Handshake and FIFO bookkeeping
   always_comb begin
      pop   = (count_q != '0);
      // The head leaves this cycle, so its slot already counts as free.
      free  = DEPTH_C - count_q + CNT_W'(pop);
      req0_ready = rst_n & (free >= ONE_C);
      req1_ready = rst_n & ((free >= TWO_C) | ((free >= ONE_C) & ~req0_valid));
      push0 = req0_valid & req0_ready;
      push1 = req1_valid & req1_ready;

      ent_d = ent_q;
      if (push0) begin
         ent_d[wr_ptr_q] = {req0_tag, req0_mem_write, req0_mem_read, req0_wdata, req0_addr};
      end
      // Lane 1 lands behind lane 0 when both transfer together.
      if (push1) begin
         ent_d[wr_ptr_q + PTR_W'(push0)] =
            {req1_tag, req1_mem_write, req1_mem_read, req1_wdata, req1_addr};
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
   end

   // Head decode and fault classification
   always_comb begin
      head    = ent_q[rd_ptr_q];
      h_addr  = head[31:0];
      h_wdata = head[63:32];
      h_rd    = head[66:64];
      h_wr    = head[69:67];
      h_tag   = head[74:70];

      is_ld   = (h_rd != 3'b000);
      is_st   = (h_wr != 3'b000);
      bad_op  = (is_ld == is_st) |
                (is_ld & (h_rd > RD_LW)) |
                (is_st & (h_wr != WR_SB) & (h_wr != WR_SH) & (h_wr != WR_SW));
      is_half = (h_rd == RD_LHU) | (h_rd == RD_LH) | (h_wr == WR_SH);
      is_word = (h_rd == RD_LW) | (h_wr == WR_SW);
      misaligned = (is_half & h_addr[0]) | (is_word & (h_addr[1:0] != 2'b00));

      // 33-bit compare so a window ending at the top of the address space
      // cannot wrap to zero.
      addr_x  = {1'b0, h_addr};
      win_lo  = {1'b0, BASE_ADDR};
      win_hi  = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);
      out_win = (addr_x < win_lo) | (addr_x >= win_hi);

      fault   = bad_op | misaligned | out_win;

      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = '0;
      mem_write = '0;
      if (pop) begin
         mem_addr  = h_addr;
         mem_wdata = h_wdata;
         mem_read  = fault ? 3'b000 : h_rd;
         mem_write = fault ? 3'b000 : h_wr;
      end
   end

   // Response register: fields update only when a head is retired.
   always_comb begin
      rsp_valid_d = pop;
      rsp_tag_d   = rsp_tag_q;
      rsp_data_d  = rsp_data_q;
      rsp_fault_d = rsp_fault_q;
      if (pop) begin
         rsp_tag_d   = h_tag;
         rsp_fault_d = fault;
         rsp_data_d  = (!fault && is_ld) ? mem_rdata : 32'h0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tag_q   <= '0;
         rsp_data_q  <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         ent_q       <= ent_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_data_q  <= rsp_data_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port
//   Bench for lsu_mem_port. Drivers present requests after the falling edge;
//   accepted requests are pushed into an expected-issue queue and an
//   expected-response queue by a behavioural model (occupancy from queue
//   length, in-order one-per-cycle service, fault rules from the op/address
//   rules). Monitors on the falling edge compare the memory command and the
//   response stream against those queues.
module tb_lsu_mem_port;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned MEMB  = 32768;
   localparam int          DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  rd;
      logic [2:0]  wr;
      logic [4:0]  tag;
   } req_t;

   typedef struct {
      req_t r;
      bit   f;
      int   cyc;
   } iss_t;

   // clock / reset
   logic clk;
   logic rst_n;
   int   cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // DUT signals
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
   logic [2:0]  req0_mem_read, req0_mem_write, req1_mem_read, req1_mem_write;
   logic [4:0]  req0_tag, req1_tag;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_read, mem_write;
   logic        rsp_valid, rsp_fault;
   logic [4:0]  rsp_tag;
   logic [31:0] rsp_data;

   lsu_mem_port #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_mem_read(req0_mem_read),
      .req0_mem_write(req0_mem_write), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_mem_read(req1_mem_read),
      .req1_mem_write(req1_mem_write), .req1_tag(req1_tag),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .rsp_fault(rsp_fault)
   );

   // Memory contents as a fixed function of the address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h1111_1111;
      if (a == 32'h8000_0004) return 32'h2222_2222;
      return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction

   assign mem_rdata = mem_fn(mem_addr);

   // scoreboard state
   int checks = 0;
   int errors = 0;
   logic [37:0] exp_q[$];      // {tag, fault, data}
   int          exp_cyc_q[$];  // cycle in which the response must be visible
   iss_t        iss_q[$];
   int          last_issue = -100;
   logic [37:0] last_rsp = '0;
   req_t        pend_q[$];
   req_t        zero_req = '{default: '0};
   logic [4:0]  next_tag = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Fault rules stated directly: op legality, natural alignment, window.
   function automatic bit fault_of(input req_t r);
      bit ld = (r.rd != 0);
      bit st = (r.wr != 0);
      int sz;
      longint a, lo, hi;
      if (ld == st) return 1;
      if (ld) begin
         if (r.rd > 5) return 1;
         sz = (r.rd == 5) ? 4 : ((r.rd == 2 || r.rd == 4) ? 2 : 1);
      end else begin
         if (!(r.wr == 1 || r.wr == 2 || r.wr == 4)) return 1;
         sz = (r.wr == 4) ? 4 : ((r.wr == 2) ? 2 : 1);
      end
      if ((r.addr % sz) != 0) return 1;
      a  = longint'({32'h0, r.addr});
      lo = longint'({32'h0, BASE});
      hi = lo + longint'(MEMB);
      if (a < lo || a >= hi) return 1;
      return 0;
   endfunction

   // Record an accepted request: in-order, one service per cycle.
   task automatic push_model(input req_t r);
      iss_t e;
      bit   f = fault_of(r);
      int   issue = (cyc + 1 > last_issue + 1) ? cyc + 1 : last_issue + 1;
      last_issue = issue;
      e.r = r; e.f = f; e.cyc = issue;
      iss_q.push_back(e);
      exp_q.push_back({r.tag, f, (f || r.rd == 0) ? 32'h0 : mem_fn(r.addr)});
      exp_cyc_q.push_back(issue + 1);
   endtask

   task automatic flush_model();
      exp_q.delete();
      exp_cyc_q.delete();
      iss_q.delete();
      last_issue = -100;
      last_rsp   = '0;
   endtask

   // driver: one cycle of lane stimulus, returns which lanes transferred
   task automatic step(input bit v0, input req_t a, input bit v1, input req_t b,
                       output bit acc0, output bit acc1);
      int  free;
      bit  er0, er1;
      @(negedge clk);
      #1;
      req0_valid = v0; req0_addr = a.addr; req0_wdata = a.wdata;
      req0_mem_read = a.rd; req0_mem_write = a.wr; req0_tag = a.tag;
      req1_valid = v1; req1_addr = b.addr; req1_wdata = b.wdata;
      req1_mem_read = b.rd; req1_mem_write = b.wr; req1_tag = b.tag;
      #1;
      // Entries still waiting (the one issuing now is already retired from
      // iss_q), so this is the free count including this cycle's pop.
      free = DEPTH - iss_q.size();
      er0  = rst_n && (free >= 1);
      er1  = rst_n && (free >= 2 || (free >= 1 && !v0));
      chk("req0_ready", 64'(req0_ready), 64'(er0));
      chk("req1_ready", 64'(req1_ready), 64'(er1));
      acc0 = v0 && req0_ready;
      acc1 = v1 && req1_ready;
      if (acc0) push_model(a);
      if (acc1) push_model(b);
   endtask

   task automatic idle(input int n);
      bit a0, a1;
      for (int i = 0; i < n; i++) step(1'b0, zero_req, 1'b0, zero_req, a0, a1);
   endtask

   // Feed pend_q through the lanes in order; rnd adds random valid gaps.
   task automatic send(input bit rnd);
      int   guard = 0;
      req_t a, b;
      bit   v0, v1, a0, a1;
      while (pend_q.size() != 0 && guard < 3000) begin
         guard++;
         a = zero_req; b = zero_req; v1 = 1'b0;
         v0 = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (v0) begin
            a  = pend_q[0];
            v1 = (pend_q.size() > 1) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (v1) b = pend_q[1];
         end else begin
            v1 = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            b  = pend_q[0];
         end
         step(v0, a, v1, b, a0, a1);
         if (v0) begin
            if (a1) pend_q.delete(1);
            if (a0) pend_q.delete(0);
         end else if (a1) begin
            pend_q.delete(0);
         end
      end
      chk("send_timeout", 64'(pend_q.size()), 64'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || iss_q.size() != 0) && n < 50) begin
         idle(1);
         n++;
      end
      idle(1);
      chk("drain_timeout", 64'(exp_q.size() + iss_q.size()), 64'd0);
   endtask

   function automatic req_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] rd, input logic [2:0] wr,
                               input logic [4:0] tag);
      req_t r;
      r.addr = addr; r.wdata = wdata; r.rd = rd; r.wr = wr; r.tag = tag;
      return r;
   endfunction

   function automatic req_t rand_req(input logic [4:0] tag);
      req_t r;
      int   k = $urandom_range(0, 9);
      logic [2:0] wr_codes [3];
      wr_codes[0] = 3'd1; wr_codes[1] = 3'd2; wr_codes[2] = 3'd4;
      case ($urandom_range(0, 9))
         0: r.addr = BASE - 32'd4;
         1: r.addr = BASE + MEMB;
         2: r.addr = BASE + MEMB - 32'd4;
         3: r.addr = 32'hFFFF_FFFC;
         default: r.addr = BASE + ($urandom_range(0, MEMB - 1) & 32'hFFFF_FFFC);
      endcase
      if ($urandom_range(0, 3) == 0) r.addr[1:0] = 2'($urandom_range(0, 3));
      r.rd = 3'd0; r.wr = 3'd0;
      if (k < 4)      r.rd = 3'($urandom_range(1, 5));
      else if (k < 8) r.wr = wr_codes[$urandom_range(0, 2)];
      else begin
         r.rd = 3'($urandom_range(0, 7));
         r.wr = 3'($urandom_range(0, 7));
      end
      r.wdata = $urandom;
      r.tag   = tag;
      return r;
   endfunction

   // monitor: memory command side
   always @(negedge clk) begin
      iss_t e;
      while (iss_q.size() != 0 && iss_q[0].cyc < cyc) begin
         chk("issue_missing_tag", 64'(iss_q[0].r.tag), 64'h3F);
         void'(iss_q.pop_front());
      end
      if (iss_q.size() != 0 && iss_q[0].cyc == cyc) begin
         e = iss_q.pop_front();
         chk("mem_read",  64'(mem_read),  64'(e.f ? 3'd0 : e.r.rd));
         chk("mem_write", 64'(mem_write), 64'(e.f ? 3'd0 : e.r.wr));
         if (!e.f) begin
            chk("mem_addr",  64'(mem_addr),  64'(e.r.addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e.r.wdata));
         end
      end else begin
         chk("mem_idle", {mem_addr, mem_wdata[25:0], mem_read, mem_write}, 64'd0);
      end
   end

   // monitor: response side
   always @(negedge clk) begin
      logic [37:0] e;
      int          ec;
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", {rsp_tag, rsp_fault, rsp_data}, 64'h0);
            errors += (rsp_valid === 1'b1 && {rsp_tag, rsp_fault, rsp_data} == 38'h0) ? 1 : 0;
         end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk("rsp_fields", {rsp_tag, rsp_fault, rsp_data}, 64'(e));
            chk("rsp_cycle", 64'(cyc), 64'(ec));
            last_rsp = e;
         end
      end else begin
         chk("rsp_hold", {rsp_tag, rsp_fault, rsp_data}, 64'(last_rsp));
         if (exp_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
            e = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            chk("rsp_missing_tag", 64'(0), 64'(e[37:33]) + 64'd1);
         end
      end
   end

   // main sequence
   initial begin
      bit a0, a1;
      rst_n = 1'b0;
      req0_valid = 0; req0_addr = 0; req0_wdata = 0; req0_mem_read = 0;
      req0_mem_write = 0; req0_tag = 0;
      req1_valid = 0; req1_addr = 0; req1_wdata = 0; req1_mem_read = 0;
      req1_mem_write = 0; req1_tag = 0;

      // reset state
      idle(3);
      chk("reset_rsp", {rsp_valid, rsp_tag, rsp_fault, rsp_data}, 64'd0);
      chk("reset_mem", {mem_addr, mem_read, mem_write}, 64'd0);
      chk("reset_ready", {req0_ready, req1_ready}, 64'd0);
      @(negedge clk); #3 rst_n = 1'b1;
      idle(2);

      // lane-0 store word
      step(1'b1, mk(32'h8000_0010, 32'hDEAD_BEEF, 3'b000, 3'b100, 5'd3),
           1'b0, zero_req, a0, a1);
      drain();

      // same-cycle loads on both lanes return in lane order
      step(1'b1, mk(32'h8000_0000, 32'h0, 3'b101, 3'b000, 5'd1),
           1'b1, mk(32'h8000_0004, 32'h0, 3'b101, 3'b000, 5'd2), a0, a1);
      drain();

      // faults: misaligned halfword, below window, just past window
      pend_q.push_back(mk(32'h8000_0003, 32'h0, 3'b100, 3'b000, 5'd4));
      pend_q.push_back(mk(32'h7FFF_FFFC, 32'h0, 3'b101, 3'b000, 5'd5));
      pend_q.push_back(mk(32'h8000_8000, 32'h0, 3'b101, 3'b000, 5'd6));
      pend_q.push_back(mk(32'h8000_7FFC, 32'h0, 3'b101, 3'b000, 5'd7));
      pend_q.push_back(mk(32'hFFFF_FFFC, 32'h1, 3'b000, 3'b100, 5'd8));
      send(1'b0);
      drain();

      // six back-to-back pairs into a four-deep queue
      for (int i = 0; i < 12; i++) begin
         pend_q.push_back(mk(BASE + 32'(i * 4), 32'(i), 3'b101, 3'b000, 5'(i + 10)));
      end
      send(1'b0);
      drain();

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         pend_q.push_back(rand_req(next_tag));
         next_tag = next_tag + 5'd1;
      end
      send(1'b1);
      drain();

      // reset with three entries queued
      step(1'b1, rand_req(5'd20), 1'b1, rand_req(5'd21), a0, a1);
      step(1'b1, rand_req(5'd22), 1'b1, rand_req(5'd23), a0, a1);
      @(negedge clk); #3 rst_n = 1'b0;
      flush_model();
      #1;
      chk("rst_mid_rsp", {rsp_valid, rsp_tag, rsp_fault, rsp_data}, 64'd0);
      chk("rst_mid_mem", {mem_addr, mem_read, mem_write}, 64'd0);
      chk("rst_mid_ready", {req0_ready, req1_ready}, 64'd0);
      idle(3);
      @(negedge clk); #3 rst_n = 1'b1;
      idle(6);

      // traffic after reset
      for (int i = 0; i < 40; i++) begin
         pend_q.push_back(rand_req(next_tag));
         next_tag = next_tag + 5'd1;
      end
      send(1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
